// File: rtl/rip_gshare_predictor_pkg.sv
// Shared types and constants for the gshare branch predictor: counter encoding,
// history type, FSM states and the saturating counter update.
package rip_branch_predictor_const;

  localparam int TABLE_DEPTH = 4;
  localparam int BP_PC_LSB   = 2;
  localparam int BP_PC_MSB   = BP_PC_LSB + TABLE_DEPTH - 1;

  typedef enum logic [1:0] {
    STRONGLY_UNTAKEN = 2'b00,
    WEAKLY_UNTAKEN   = 2'b01,
    WEAKLY_TAKEN     = 2'b10,
    STRONGLY_TAKEN   = 2'b11
  } bp_weight_t;

  typedef logic [TABLE_DEPTH-1:0] bp_ghr_t;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

  function automatic bp_weight_t bp_sat_update(bp_weight_t w, logic taken);
    logic [1:0] v;
    v = w;
    if (taken && v != 2'b11)
      v = v + 2'd1;
    else if (!taken && v != 2'b00)
      v = v - 2'd1;
    return bp_weight_t'(v);
  endfunction

endpackage

// File: rtl/rip_gshare_predictor_if.sv
// Lookup (IF side) and resolve (EX side) signals of the gshare predictor.
// master = pipeline driving requests, slave = predictor.
interface rip_gshare_predictor_if
  import rip_branch_predictor_const::*;
#(
  parameter int IDX_W = TABLE_DEPTH
) ();

  logic             ready_o;
  logic             pred_valid_i;
  logic [31:0]      pred_pc_i;
  logic             pred_valid_o;
  logic             pred_taken_o;
  logic [IDX_W-1:0] pred_index_o;
  logic [IDX_W-1:0] pred_ghr_o;
  logic             upd_valid_i;
  logic [IDX_W-1:0] upd_index_i;
  logic [IDX_W-1:0] upd_ghr_i;
  logic             upd_taken_i;
  logic             upd_mispred_i;

  modport master (
    input  ready_o, pred_valid_o, pred_taken_o, pred_index_o, pred_ghr_o,
    output pred_valid_i, pred_pc_i,
           upd_valid_i, upd_index_i, upd_ghr_i, upd_taken_i, upd_mispred_i
  );

  modport slave (
    output ready_o, pred_valid_o, pred_taken_o, pred_index_o, pred_ghr_o,
    input  pred_valid_i, pred_pc_i,
           upd_valid_i, upd_index_i, upd_ghr_i, upd_taken_i, upd_mispred_i
  );

endinterface

// File: rtl/rip_gshare_predictor_counter_table.sv
// 2-bit saturating counter array: one synchronous write port (init or
// read-modify-write update) and one combinational read port with write bypass.
module rip_bp_counter_table
  import rip_branch_predictor_const::*;
#(
  parameter int IDX_W = TABLE_DEPTH
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic             i_wr_init,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bp_weight_t       o_rd_data
);

  bp_weight_t r_mem [0:(1<<IDX_W)-1];
  bp_weight_t w_wr_data;

  assign w_wr_data = i_wr_init ? WEAKLY_UNTAKEN
                               : bp_sat_update(r_mem[i_wr_idx], i_wr_taken);

  always_ff @(posedge clk) begin
    if (i_wr_en)
      r_mem[i_wr_idx] <= w_wr_data;
  end

  // A same-cycle write to the looked-up entry is forwarded so the lookup sees the new value.
  assign o_rd_data = (i_wr_en && (i_wr_idx == i_rd_idx)) ? w_wr_data : r_mem[i_rd_idx];

endmodule

// File: rtl/rip_gshare_predictor.sv
// Gshare direction predictor: init sweep FSM, speculative GHR with mispredict
// repair, PC^GHR index hash and registered prediction outputs.
module rip_gshare_predictor
  import rip_branch_predictor_const::*;
#(
  parameter int IDX_W  = TABLE_DEPTH,
  parameter int PC_LSB = BP_PC_LSB,
  parameter int PC_MSB = BP_PC_MSB
) (
  input  logic                   clk,
  input  logic                   rst,
  rip_gshare_predictor_if.slave  bp
);

  bp_state_t        r_state;
  bp_state_t        w_state_nxt;
  logic [IDX_W-1:0] r_sweep_cnt;
  logic [IDX_W-1:0] r_ghr;
  logic             r_pred_valid;
  logic             r_pred_taken;
  logic [IDX_W-1:0] r_pred_index;
  logic [IDX_W-1:0] r_pred_ghr;

  logic             w_run;
  logic             w_ready;
  logic             w_sweep_last;
  logic             w_upd_acc;
  logic             w_recover;
  logic             w_pred_acc;
  logic [IDX_W-1:0] w_idx;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  bp_weight_t       w_rd_weight;
  logic             w_taken;

  assign w_run        = (r_state == BP_RUN);
  assign w_sweep_last = (r_sweep_cnt == {IDX_W{1'b1}});
  assign w_upd_acc    = w_run && bp.upd_valid_i;
  assign w_recover    = w_upd_acc && bp.upd_mispred_i;
  // IF is being flushed during recovery, so a lookup in that cycle is discarded.
  assign w_pred_acc   = w_run && bp.pred_valid_i && !w_recover;
  assign w_idx        = bp.pred_pc_i[PC_MSB:PC_LSB] ^ r_ghr;
  assign w_wr_en      = !w_run || w_upd_acc;
  assign w_wr_idx     = w_run ? bp.upd_index_i : r_sweep_cnt;
  assign w_taken      = w_rd_weight[1];

  rip_bp_counter_table #(.IDX_W(IDX_W)) u_table (
    .clk        (clk),
    .i_wr_en    (w_wr_en),
    .i_wr_init  (!w_run),
    .i_wr_idx   (w_wr_idx),
    .i_wr_taken (bp.upd_taken_i),
    .i_rd_idx   (w_idx),
    .o_rd_data  (w_rd_weight)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= BP_INIT;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      if (!w_run)
        r_sweep_cnt <= r_sweep_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      BP_INIT: if (w_sweep_last) w_state_nxt = BP_RUN;
      BP_RUN:  w_ready = 1'b1;
      default: w_state_nxt = BP_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr        <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_index <= '0;
      r_pred_ghr   <= '0;
    end else begin
      r_pred_valid <= w_pred_acc;
      if (w_pred_acc) begin
        r_pred_taken <= w_taken;
        r_pred_index <= w_idx;
        r_pred_ghr   <= r_ghr;
      end
      if (w_recover)
        r_ghr <= {bp.upd_ghr_i[IDX_W-2:0], bp.upd_taken_i};
      else if (w_pred_acc)
        r_ghr <= {r_ghr[IDX_W-2:0], w_taken};
    end
  end

  assign bp.ready_o      = w_ready;
  assign bp.pred_valid_o = r_pred_valid;
  assign bp.pred_taken_o = r_pred_taken;
  assign bp.pred_index_o = r_pred_index;
  assign bp.pred_ghr_o   = r_pred_ghr;

endmodule
